axil_adder_slave: RTL and testbench
===================================

Name: axil_adder_slave

Overview:
AXI4-Lite responder holding two operand registers and exposing their registered sum and carry as read-only registers. It is the slave end of the bus our AXI-Lite initiator benches drive: operands are written at 0x00 and 0x04, and the sum and status are read at 0x18 and 0x1C. It sits behind the system interconnect on the s1_axi port.

Parameters:
DATA_WIDTH, 32, data bus and operand width.
ADDR_WIDTH, 8, byte address width; bits [1:0] are ignored.

Ports:
s1_axi_aclk  in  1  clock
s1_axi_areset  in  1  synchronous reset, active-high
s1_axi_awaddr  in  ADDR_WIDTH  write address
s1_axi_awvalid  in  1  write address valid
s1_axi_awready  out  1  write address ready
s1_axi_wdata  in  DATA_WIDTH  write data
s1_axi_wstrb  in  DATA_WIDTH/8  byte strobes
s1_axi_wvalid  in  1  write data valid
s1_axi_wready  out  1  write data ready
s1_axi_bresp  out  2  write response
s1_axi_bvalid  out  1  write response valid
s1_axi_bready  in  1  write response ready
s1_axi_araddr  in  ADDR_WIDTH  read address
s1_axi_arvalid  in  1  read address valid
s1_axi_arready  out  1  read address ready
s1_axi_rdata  out  DATA_WIDTH  read data
s1_axi_rresp  out  2  read response
s1_axi_rvalid  out  1  read valid
s1_axi_rready  in  1  read ready

Behaviour:
- Clocking and reset: one clock, s1_axi_aclk. Synchronous active-high reset s1_axi_areset clears all outputs, OP_A, OP_B, SUM and STATUS to 0. Reset during an outstanding transaction drops bvalid/rvalid with no response sent.
- Register map:
  - 0x00 OP_A: RW.
  - 0x04 OP_B: RW.
  - 0x18 SUM: RO.
  - 0x1C STATUS: RO; bit0 CARRY, bit1 VALID, others 0.
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: when awvalid && wvalid, pulse awready and wready together for 1 cycle and commit the write on that edge. Go to W_RESP with bvalid=1.
  - A lone awvalid or a lone wvalid waits; there is no partial acceptance.
  - W_RESP: hold bvalid and bresp until bready, then return to W_IDLE. awready/wready stay 0 while in W_RESP.
- Write commit:
  - Byte lane i of OP_A/OP_B is updated only where wstrb[i]=1.
  - Writes to 0x00 or 0x04 give bresp=2'b00 (OKAY).
  - Writes to 0x18, 0x1C or any unmapped address are ignored and give bresp=2'b10 (SLVERR).
- Adder, 1-cycle registered:
  - Every cycle, {CARRY,SUM} <= OP_A + OP_B, computed DATA_WIDTH+1 bits wide.
  - An accepted operand write clears VALID on the commit edge; VALID sets on the following edge.
  - Result of a write committed at edge N is visible at SUM from edge N+1.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: when arvalid && !rvalid, pulse arready for 1 cycle, register rdata/rresp on that edge, and set rvalid. Read latency is 1 cycle from the arready handshake to rvalid.
  - R_DATA: hold rdata/rresp/rvalid until rready.
  - Mapped addresses return rresp=2'b00. Unmapped addresses return rdata=0 and rresp=2'b10.
- Read and write channels are independent. When a read and a write hit the same register in the same cycle, the read returns the pre-write value.

Optional Feature:
ADDER_SAT_EN.
- Defined: SUM saturates to all ones when the carry out is 1; CARRY still reports the overflow.
- Undefined: SUM is the wrapped modulo-2^DATA_WIDTH result.

Decomposition:
- Shared package axil_adder_pkg:
  - Address constants ADDR_OP_A=0x00, ADDR_OP_B=0x04, ADDR_SUM=0x18, ADDR_STATUS=0x1C.
  - Response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - FSM state typedefs for the write and read FSMs.
- One sub-module, axil_adder_core: operand registers, strobe merge, registered sum/carry/valid. The top holds both AXI FSMs and address decode.

Test Plan:
- Write OP_A=39 and OP_B=40 (wstrb=0xF), then read 0x18 and 0x1C -> rdata=79 then 0x2, bresp and rresp OKAY.
- OP_A=0xFFFFFFFF, OP_B=2 -> SUM=0x00000001, STATUS=0x3. With ADDER_SAT_EN: SUM=0xFFFFFFFF, STATUS=0x3.
- OP_A=0, then write 0x12345678 with wstrb=0x1 -> OP_A reads 0x00000078.
- Write 0xDEAD to 0x18 -> bresp=2'b10, SUM unchanged. Read 0x40 -> rdata=0, rresp=2'b10.
- Hold bready low for 5 cycles with a second write pending -> bvalid held and awready/wready stay 0. Second write accepted on the cycle after bready rises.
- Assert s1_axi_areset while rvalid=1 -> next cycle rvalid=0 and all registers read 0.

Source files
------------

// File: rtl/axil_adder_pkg.sv
// Shared definitions for the AXI4-Lite adder slave: register offsets,
// response codes and the write/read channel FSM state types.
package axil_adder_pkg;

  // Byte offsets of the register map; address bits [1:0] are not decoded.
  localparam int unsigned ADDR_OP_A   = 32'h00;
  localparam int unsigned ADDR_OP_B   = 32'h04;
  localparam int unsigned ADDR_SUM    = 32'h18;
  localparam int unsigned ADDR_STATUS = 32'h1C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

endpackage

// File: rtl/axil_adder_core.sv
// Operand registers with byte-strobe merge and a one-cycle registered adder.
// Build option: define ADDER_SAT_EN to saturate SUM to all ones on carry out;
// otherwise SUM wraps modulo 2^DATA_WIDTH.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   wr_a_i, wr_b_i      commit strobe for OP_A / OP_B
//   wdata_i, wstrb_i    write data and byte strobes
//   op_a_o, op_b_o      current operand values
//   sum_o, carry_o      registered sum and carry out
//   valid_o             sum reflects the most recently written operands
module axil_adder_core
  import axil_adder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_a_i,
  input  logic                    wr_b_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  output logic [DATA_WIDTH-1:0]   op_a_o,
  output logic [DATA_WIDTH-1:0]   op_b_o,
  output logic [DATA_WIDTH-1:0]   sum_o,
  output logic                    carry_o,
  output logic                    valid_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  carry_q;
  logic                  valid_q, valid_d;
  logic                  pend_q;
  logic [DATA_WIDTH:0]   add_c;
  logic                  wr_any_c;

  assign wr_any_c = wr_a_i | wr_b_i;

  // Byte-lane merge of write data into the selected operand.
  always_comb begin
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (wstrb_i[i]) begin
        if (wr_a_i) op_a_d[8*i +: 8] = wdata_i[8*i +: 8];
        if (wr_b_i) op_b_d[8*i +: 8] = wdata_i[8*i +: 8];
      end
    end
  end

  // Full-width add so the carry out is kept.
  always_comb begin
    add_c = {1'b0, op_a_q} + {1'b0, op_b_q};
`ifdef ADDER_SAT_EN
    sum_d = add_c[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : add_c[DATA_WIDTH-1:0];
`else
    sum_d = add_c[DATA_WIDTH-1:0];
`endif
  end

  // VALID drops on an operand commit and returns once the adder has caught up;
  // it stays low out of reset until the first operand write.
  always_comb begin
    valid_d = wr_any_c ? 1'b0 : (valid_q | pend_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      carry_q <= add_c[DATA_WIDTH];
      valid_q <= valid_d;
      pend_q  <= wr_any_c;
    end
  end

  assign op_a_o  = op_a_q;
  assign op_b_o  = op_b_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/axil_adder_slave.sv
// AXI4-Lite slave exposing two RW operands (0x00, 0x04) and their registered
// sum (0x18) and status {VALID, CARRY} (0x1C). Independent write and read FSMs.
// Build option: ADDER_SAT_EN (saturating sum, handled in axil_adder_core).
// Ports: s1_axi_aclk / s1_axi_areset (sync, active-high), AXI4-Lite AW, W, B,
// AR and R channels on the s1_axi_* prefix. The ready outputs are decoded
// from FSM state and the request valids so a handshake completes in the
// cycle the request is presented.
module axil_adder_slave
  import axil_adder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready
);

  localparam int unsigned IW = ADDR_WIDTH - 2;

  localparam logic [IW-1:0] IDX_OP_A   = IW'(ADDR_OP_A >> 2);
  localparam logic [IW-1:0] IDX_OP_B   = IW'(ADDR_OP_B >> 2);
  localparam logic [IW-1:0] IDX_SUM    = IW'(ADDR_SUM >> 2);
  localparam logic [IW-1:0] IDX_STATUS = IW'(ADDR_STATUS >> 2);

  wstate_e               w_state_q, w_state_d;
  rstate_e               r_state_q, r_state_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  awready_c, wready_c, arready_c, wr_commit_c;
  logic                  aw_is_a_c, aw_is_b_c;
  logic [IW-1:0]         aw_idx, ar_idx;
  logic [DATA_WIDTH-1:0] rd_mux_c;
  logic                  rd_hit_c;

  logic [DATA_WIDTH-1:0] op_a, op_b, sum;
  logic                  carry, valid;

  assign aw_idx    = s1_axi_awaddr[ADDR_WIDTH-1:2];
  assign ar_idx    = s1_axi_araddr[ADDR_WIDTH-1:2];
  assign aw_is_a_c = (aw_idx == IDX_OP_A);
  assign aw_is_b_c = (aw_idx == IDX_OP_B);

  // Byte-offset bits are deliberately not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s1_axi_awaddr[1:0], s1_axi_araddr[1:0]};

  axil_adder_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .clk_i   (s1_axi_aclk),
    .rst_i   (s1_axi_areset),
    .wr_a_i  (wr_commit_c & aw_is_a_c),
    .wr_b_i  (wr_commit_c & aw_is_b_c),
    .wdata_i (s1_axi_wdata),
    .wstrb_i (s1_axi_wstrb),
    .op_a_o  (op_a),
    .op_b_o  (op_b),
    .sum_o   (sum),
    .carry_o (carry),
    .valid_o (valid)
  );

  // Write channel: address and data are only accepted together.
  always_comb begin
    w_state_d   = w_state_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    awready_c   = 1'b0;
    wready_c    = 1'b0;
    wr_commit_c = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s1_axi_awvalid && s1_axi_wvalid) begin
          awready_c   = 1'b1;
          wready_c    = 1'b1;
          wr_commit_c = 1'b1;
          bvalid_d    = 1'b1;
          bresp_d     = (aw_is_a_c || aw_is_b_c) ? RESP_OKAY : RESP_SLVERR;
          w_state_d   = W_RESP;
        end
      end
      W_RESP: begin
        if (s1_axi_bready) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read decode; unmapped addresses return zero with SLVERR.
  always_comb begin
    rd_mux_c = '0;
    rd_hit_c = 1'b1;
    if (ar_idx == IDX_OP_A)        rd_mux_c = op_a;
    else if (ar_idx == IDX_OP_B)   rd_mux_c = op_b;
    else if (ar_idx == IDX_SUM)    rd_mux_c = sum;
    else if (ar_idx == IDX_STATUS) rd_mux_c = {(DATA_WIDTH-2)'(0), valid, carry};
    else                           rd_hit_c = 1'b0;
  end

  // Read channel: data captured on the address handshake edge, so a
  // same-cycle write to the same register is not yet visible.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    arready_c = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (s1_axi_arvalid && !rvalid_q) begin
          arready_c = 1'b1;
          rvalid_d  = 1'b1;
          rdata_d   = rd_mux_c;
          rresp_d   = rd_hit_c ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s1_axi_rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      w_state_q <= W_IDLE;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s1_axi_awready = awready_c;
  assign s1_axi_wready  = wready_c;
  assign s1_axi_arready = arready_c;
  assign s1_axi_bvalid  = bvalid_q;
  assign s1_axi_bresp   = bresp_q;
  assign s1_axi_rvalid  = rvalid_q;
  assign s1_axi_rdata   = rdata_q;
  assign s1_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axil_adder_slave.sv
// Directed bench for axil_adder_slave: register access, carry/saturation,
// strobes, error responses, B-channel backpressure, same-cycle read/write
// ordering and reset during an outstanding read.
module tb_axil_adder_slave;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [7:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [7:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_adder_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8)
  ) dut (
    .s1_axi_aclk    (clk),
    .s1_axi_areset  (areset),
    .s1_axi_awaddr  (awaddr),
    .s1_axi_awvalid (awvalid),
    .s1_axi_awready (awready),
    .s1_axi_wdata   (wdata),
    .s1_axi_wstrb   (wstrb),
    .s1_axi_wvalid  (wvalid),
    .s1_axi_wready  (wready),
    .s1_axi_bresp   (bresp),
    .s1_axi_bvalid  (bvalid),
    .s1_axi_bready  (bready),
    .s1_axi_araddr  (araddr),
    .s1_axi_arvalid (arvalid),
    .s1_axi_arready (arready),
    .s1_axi_rdata   (rdata),
    .s1_axi_rresp   (rresp),
    .s1_axi_rvalid  (rvalid),
    .s1_axi_rready  (rready)
  );

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    n = 0;
    while (!(awready && wready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL wr_accept_timeout addr=%h", addr);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    resp = 2'b11;
    n = 0;
    while (!bvalid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL bvalid_timeout addr=%h", addr);
    end else begin
      resp = bresp;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL ar_accept_timeout addr=%h", addr);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    data = 32'hxxxx_xxxx; resp = 2'b11;
    n = 0;
    while (!rvalid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL rvalid_timeout addr=%h", addr);
    end else begin
      data = rdata; resp = rresp;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    logic [7:0]  addrs [4];
    addrs = '{8'h00, 8'h04, 8'h18, 8'h1C};
    checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || awready !== 1'b0 || arready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got bv=%b rv=%b awr=%b arr=%b exp all 0",
               bvalid, rvalid, awready, arready);
    end
    foreach (addrs[i]) begin
      axi_read(addrs[i], d, r);
      checks++;
      if (d !== 32'h0 || r !== 2'b00) begin
        errors++;
        $display("FAIL reset_reg_%h got %h/%b exp 00000000/00", addrs[i], d, r);
      end
    end
  endtask

  task automatic test_basic_add();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(8'h00, 32'd39, 4'hF, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL basic_bresp_a got %b exp 00", r); end
    axi_write(8'h04, 32'd40, 4'hF, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL basic_bresp_b got %b exp 00", r); end
    axi_read(8'h18, d, r);
    checks++;
    if (d !== 32'd79 || r !== 2'b00) begin
      errors++; $display("FAIL basic_sum got %h/%b exp 0000004f/00", d, r);
    end
    axi_read(8'h1C, d, r);
    checks++;
    if (d !== 32'h2 || r !== 2'b00) begin
      errors++; $display("FAIL basic_status got %h/%b exp 00000002/00", d, r);
    end
  endtask

  task automatic test_carry();
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] exp_sum;
`ifdef ADDER_SAT_EN
    exp_sum = 32'hFFFF_FFFF;
`else
    exp_sum = 32'h0000_0001;
`endif
    axi_write(8'h00, 32'hFFFF_FFFF, 4'hF, r);
    axi_write(8'h04, 32'h0000_0002, 4'hF, r);
    axi_read(8'h18, d, r);
    checks++;
    if (d !== exp_sum) begin
      errors++; $display("FAIL carry_sum got %h exp %h", d, exp_sum);
    end
    axi_read(8'h1C, d, r);
    checks++;
    if (d !== 32'h3) begin
      errors++; $display("FAIL carry_status got %h exp 00000003", d);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(8'h00, 32'h0, 4'hF, r);
    axi_write(8'h00, 32'h1234_5678, 4'h1, r);
    axi_read(8'h00, d, r);
    checks++;
    if (d !== 32'h0000_0078) begin
      errors++; $display("FAIL strobe_op_a got %h exp 00000078", d);
    end
    axi_write(8'h04, 32'hAABB_CC00, 4'hC, r);
    axi_read(8'h04, d, r);
    checks++;
    if (d !== 32'hAABB_0002) begin
      errors++; $display("FAIL strobe_op_b got %h exp aabb0002", d);
    end
    axi_write(8'h04, 32'h0000_0002, 4'hF, r);
  endtask

  task automatic test_slverr();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(8'h18, 32'h0000_DEAD, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL slverr_wr_sum got %b exp 10", r); end
    axi_write(8'h1C, 32'hFFFF_FFFF, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL slverr_wr_status got %b exp 10", r); end
    axi_write(8'h20, 32'h1, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL slverr_wr_unmapped got %b exp 10", r); end
    axi_read(8'h18, d, r);
    checks++;
    if (d !== 32'h0000_007A || r !== 2'b00) begin
      errors++; $display("FAIL slverr_sum_kept got %h/%b exp 0000007a/00", d, r);
    end
    axi_read(8'h40, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      errors++; $display("FAIL slverr_rd_unmapped got %h/%b exp 00000000/10", d, r);
    end
    axi_read(8'h05, d, r);
    checks++;
    if (d !== 32'h2 || r !== 2'b00) begin
      errors++; $display("FAIL low_bits_ignored got %h/%b exp 00000002/00", d, r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [1:0]  r;
    @(negedge clk);
    awaddr = 8'h00; wdata = 32'd5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    checks++;
    if (awready !== 1'b1 || wready !== 1'b1) begin
      errors++; $display("FAIL bp_first_accept got awr=%b wr=%b exp 1 1", awready, wready);
    end
    @(posedge clk); #1;
    awaddr = 8'h04; wdata = 32'd7;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_cycle%0d got bv=%b awr=%b wr=%b exp 1 0 0",
                 c, bvalid, awready, wready);
      end
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++;
      $display("FAIL bp_second_accept got bv=%b awr=%b wr=%b exp 0 1 1",
               bvalid, awready, wready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++; $display("FAIL bp_second_bresp got bv=%b br=%b exp 1 00", bvalid, bresp);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    axi_read(8'h18, d, r);
    checks++;
    if (d !== 32'd12) begin errors++; $display("FAIL bp_sum got %h exp 0000000c", d); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d;
    logic [1:0]  r;
    @(negedge clk);
    awaddr = 8'h00; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h00; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'd5 || bvalid !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_prewrite got rv=%b rd=%h bv=%b exp 1 00000005 1",
               rvalid, rdata, bvalid);
    end
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    axi_read(8'h00, d, r);
    checks++;
    if (d !== 32'h55) begin errors++; $display("FAIL same_cycle_after got %h exp 00000055", d); end
  endtask

  task automatic test_reset_during_read();
    logic [31:0] d;
    logic [1:0]  r;
    logic [7:0]  addrs [4];
    addrs = '{8'h00, 8'h04, 8'h18, 8'h1C};
    @(negedge clk);
    araddr = 8'h18; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin errors++; $display("FAIL rst_rd_pending got rv=%b exp 1", rvalid); end
    @(negedge clk);
    areset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rvalid !== 1'b0 || bvalid !== 1'b0) begin
      errors++; $display("FAIL rst_rd_dropped got rv=%b bv=%b exp 0 0", rvalid, bvalid);
    end
    @(negedge clk);
    areset = 1'b0;
    foreach (addrs[i]) begin
      axi_read(addrs[i], d, r);
      checks++;
      if (d !== 32'h0) begin
        errors++; $display("FAIL rst_rd_reg_%h got %h exp 00000000", addrs[i], d);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
    #1;
    test_reset();
    test_basic_add();
    test_carry();
    test_strobe();
    test_slverr();
    test_back_to_back();
    test_same_cycle();
    test_reset_during_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
